// File: rtl/fmul_sched.sv
// Round-robin scheduler that shares one fixed-latency FMUL32 pipeline between
// REQ_NUM requesters. A tag shift register follows each issued operation through
// the multiplier. The result goes back to the issuing requester through a
// one-entry valid/ready buffer per requester.
module fmul_sched #(
  parameter int unsigned REQ_NUM       = 4,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned OPERATION_NUM = 4,
  parameter int unsigned LATENCY       = 2,
  localparam int unsigned OPC_W        = $clog2(OPERATION_NUM)
) (
  input  logic                       clk,
  input  logic                       rst,
  // requester side
  input  logic [REQ_NUM-1:0]         req_valid,
  output logic [REQ_NUM-1:0]         req_ready,
  input  logic [REQ_NUM*DATA_W-1:0]  req_op1,
  input  logic [REQ_NUM*DATA_W-1:0]  req_op2,
  input  logic [REQ_NUM*OPC_W-1:0]   req_opc,
  input  logic [REQ_NUM*2-1:0]       req_rmode,
  // multiplier side
  output logic [DATA_W-1:0]          fmul_op1,
  output logic [DATA_W-1:0]          fmul_op2,
  output logic [OPC_W-1:0]           fmul_opc,
  output logic [1:0]                 fmul_rmode,
  input  logic [DATA_W-1:0]          fmul_result,
  input  logic                       fmul_val,
  // response side
  output logic [REQ_NUM-1:0]         rsp_valid,
  input  logic [REQ_NUM-1:0]         rsp_ready,
  output logic [REQ_NUM*DATA_W-1:0]  rsp_result,
  output logic [REQ_NUM-1:0]         rsp_flag,
  output logic                       idle
);

  localparam int unsigned PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  // Per-requester state
  logic [REQ_NUM-1:0] busy_q, busy_d;
  logic [REQ_NUM-1:0] rsp_valid_q, rsp_valid_d;
  logic [REQ_NUM-1:0] rsp_flag_q;
  logic [DATA_W-1:0]  rsp_result_q [REQ_NUM];

  // Arbitration
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic [REQ_NUM-1:0] eligible;
  logic [REQ_NUM-1:0] grant_vec;
  logic               grant;
  logic [REQ_NUM-1:0] rsp_hs;

  // Tag pipe tracking operations inside FMUL32
  logic [LATENCY-1:0] tag_v_q;
  logic [PTR_W-1:0]   tag_id_q [LATENCY];
  logic               cap_v;
  logic [PTR_W-1:0]   cap_id;

  assign eligible = req_valid & ~busy_q;
  assign rsp_hs   = rsp_valid_q & rsp_ready;
  assign cap_v    = tag_v_q[LATENCY-1];
  assign cap_id   = tag_id_q[LATENCY-1];

  // Find the first eligible requester at or after ptr, wrapping around.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = ptr_q;
    for (int unsigned j = 0; j < REQ_NUM; j++) begin
      idx = (32'(ptr_q) + j) % REQ_NUM;
      if (!grant_any && eligible[idx[PTR_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = idx[PTR_W-1:0];
      end
    end
  end

  // One-hot grant, suppressed while reset is asserted.
  always_comb begin
    grant_vec = '0;
    if (grant_any && !rst) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  assign req_ready = grant_vec;
  assign grant     = |grant_vec;

  // With no grant, grant_idx equals ptr, so the multiplier sees requester ptr's fields.
  assign fmul_op1   = req_op1[32'(grant_idx) * DATA_W +: DATA_W];
  assign fmul_op2   = req_op2[32'(grant_idx) * DATA_W +: DATA_W];
  assign fmul_opc   = req_opc[32'(grant_idx) * OPC_W +: OPC_W];
  assign fmul_rmode = req_rmode[32'(grant_idx) * 2 +: 2];

  // Next-state for pointer, busy flags and response valids.
  always_comb begin
    ptr_d       = ptr_q;
    busy_d      = (busy_q | grant_vec) & ~rsp_hs;
    rsp_valid_d = rsp_valid_q & ~rsp_hs;
    if (grant) begin
      ptr_d = (32'(grant_idx) == REQ_NUM - 1) ? '0 : grant_idx + 1'b1;
    end
    // A requester has at most one operation outstanding, so a capture never
    // collides with a response handshake on the same buffer.
    if (cap_v) begin
      rsp_valid_d[cap_id] = 1'b1;
    end
  end

  // Control state with synchronous reset; clearing tag valids drops in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      busy_q      <= '0;
      rsp_valid_q <= '0;
      tag_v_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      tag_v_q[0]  <= grant;
      for (int s = 1; s < LATENCY; s++) begin
        tag_v_q[s] <= tag_v_q[s-1];
      end
    end
  end

  // Datapath registers: tag ids and response buffers need no reset.
  always_ff @(posedge clk) begin
    tag_id_q[0] <= grant_idx;
    for (int s = 1; s < LATENCY; s++) begin
      tag_id_q[s] <= tag_id_q[s-1];
    end
    if (cap_v) begin
      rsp_result_q[cap_id] <= fmul_result;
      rsp_flag_q[cap_id]   <= fmul_val;
    end
  end

  // Flatten the response buffers onto the packed output bus.
  always_comb begin
    rsp_result = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      rsp_result[i*DATA_W +: DATA_W] = rsp_result_q[i];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_flag  = rsp_flag_q;
  assign idle      = ~|busy_q;

endmodule

// File: tb/tb_fmul_sched.sv
// Scoreboard bench for fmul_sched with a table-driven FMUL32 stand-in.
module tb_fmul_sched;

  localparam int REQ_NUM = 4;
  localparam int DATA_W  = 32;
  localparam int OPC_W   = 2;
  localparam int LATENCY = 2;
  localparam int NVEC    = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [REQ_NUM-1:0]        req_valid;
  logic [REQ_NUM-1:0]        req_ready;
  logic [REQ_NUM*DATA_W-1:0] req_op1, req_op2;
  logic [REQ_NUM*OPC_W-1:0]  req_opc;
  logic [REQ_NUM*2-1:0]      req_rmode;
  logic [DATA_W-1:0]         fmul_op1, fmul_op2, fmul_result;
  logic [OPC_W-1:0]          fmul_opc;
  logic [1:0]                fmul_rmode;
  logic                      fmul_val;
  logic [REQ_NUM-1:0]        rsp_valid, rsp_ready, rsp_flag;
  logic [REQ_NUM*DATA_W-1:0] rsp_result;
  logic                      idle;

  fmul_sched #(.REQ_NUM(REQ_NUM), .DATA_W(DATA_W), .OPERATION_NUM(4), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_opc(req_opc), .req_rmode(req_rmode),
    .fmul_op1(fmul_op1), .fmul_op2(fmul_op2), .fmul_opc(fmul_opc), .fmul_rmode(fmul_rmode),
    .fmul_result(fmul_result), .fmul_val(fmul_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flag(rsp_flag), .idle(idle)
  );

  always #5 clk = ~clk;

  // Hand-computed IEEE-754 single products; the last-but-one vector reports val=0.
  logic [31:0] v_op1 [NVEC] = '{32'h40000000, 32'h3FC00000, 32'h40800000, 32'hC0000000,
                                32'h3F800000, 32'h41200000, 32'h7F000000, 32'h40A00000};
  logic [31:0] v_op2 [NVEC] = '{32'h40400000, 32'h40000000, 32'h3F000000, 32'h40400000,
                                32'h3F800000, 32'h41200000, 32'h7F000000, 32'h40000000};
  logic [1:0]  v_rm  [NVEC] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [31:0] v_res [NVEC] = '{32'h40C00000, 32'h40400000, 32'h40000000, 32'hC0C00000,
                                32'h3F800000, 32'h42C80000, 32'h7F800000, 32'h41200000};
  logic        v_flag [NVEC] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  // FMUL32 stand-in: LATENCY-deep pipe returning the tabulated product.
  logic [31:0] p_res [LATENCY];
  logic        p_val [LATENCY];

  function automatic logic [32:0] fmul_lookup(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] rm, input logic [1:0] opc);
    logic [32:0] r;
    r = {1'b0, 32'hDEADBEEF};
    for (int k = 0; k < NVEC; k++) begin
      if (v_op1[k] == a && v_op2[k] == b && v_rm[k] == rm && opc == 2'd0) begin
        r = {v_flag[k], v_res[k]};
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    {p_val[0], p_res[0]} <= fmul_lookup(fmul_op1, fmul_op2, fmul_rmode, fmul_opc);
    for (int s = 1; s < LATENCY; s++) begin
      p_val[s] <= p_val[s-1];
      p_res[s] <= p_res[s-1];
    end
  end
  assign fmul_result = p_res[LATENCY-1];
  assign fmul_val    = p_val[LATENCY-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: {flag, result} expected per requester, pushed at grant time.
  logic [32:0] exp_q [REQ_NUM][$];
  int          glog [$];
  int          vsel [REQ_NUM];
  bit          hold_valid = 1'b0;

  task automatic drive();
    for (int i = 0; i < REQ_NUM; i++) begin
      req_op1[i*DATA_W +: DATA_W] = v_op1[vsel[i]];
      req_op2[i*DATA_W +: DATA_W] = v_op2[vsel[i]];
      req_rmode[i*2 +: 2]         = v_rm[vsel[i]];
      req_opc[i*OPC_W +: OPC_W]   = 2'd0;
    end
  endtask

  // Called at a negedge: record grants, then move to just after the next posedge.
  task automatic step();
    logic [REQ_NUM-1:0] g;
    int gi;
    g  = req_valid & req_ready;
    gi = -1;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (g[i]) begin
        exp_q[i].push_back({v_flag[vsel[i]], v_res[vsel[i]]});
        gi = i;
      end
    end
    glog.push_back(gi);
    @(posedge clk);
    #1;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (g[i]) begin
        if (hold_valid) vsel[i] = (vsel[i] + 1) % NVEC;
        else req_valid[i] = 1'b0;
      end
    end
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      step();
    end
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    req_valid = '0;
    for (int i = 0; i < REQ_NUM; i++) exp_q[i].delete();
    run(n);
    rst = 1'b0;
    glog.delete();
  endtask

  task automatic drain();
    int tot;
    req_valid  = '0;
    hold_valid = 1'b0;
    rsp_ready  = '1;
    run(8);
    tot = 0;
    for (int i = 0; i < REQ_NUM; i++) tot += exp_q[i].size();
    chk("drain_idle", idle, 1);
    chk("drain_queues_empty", tot, 0);
    glog.delete();
  endtask

  // Monitor: legality of grants, response latency, hold/stability and scoreboard.
  logic [REQ_NUM-1:0] pending, prev_v, prev_hs, prev_f;
  logic [31:0]        prev_r [REQ_NUM];
  int                 issue_cyc [REQ_NUM];

  always @(negedge clk) begin : monitor
    logic [31:0] r;
    logic [32:0] e;
    if (rst) begin
      pending = '0;
      prev_v  = '0;
      prev_hs = '0;
    end else begin
      chk("ready_onehot", $onehot0(req_ready), 1);
      for (int i = 0; i < REQ_NUM; i++) begin
        r = rsp_result[i*DATA_W +: DATA_W];
        if (req_ready[i]) begin
          chk("grant_not_busy", pending[i], 0);
          chk("grant_has_valid", req_valid[i], 1);
          issue_cyc[i] = cyc;
        end
        if (rsp_valid[i]) chk("rsp_expected", pending[i], 1);
        if (rsp_valid[i] && !prev_v[i]) chk("rsp_latency", cyc - issue_cyc[i], LATENCY + 1);
        if (prev_v[i] && !prev_hs[i]) begin
          chk("rsp_held", rsp_valid[i], 1);
          chk("rsp_stable", {rsp_flag[i], r}, {prev_f[i], prev_r[i]});
        end
        if (rsp_valid[i] && rsp_ready[i]) begin
          chk("rsp_queued", exp_q[i].size() != 0, 1);
          if (exp_q[i].size() != 0) begin
            e = exp_q[i].pop_front();
            chk("rsp_result", r, e[31:0]);
            chk("rsp_flag", rsp_flag[i], e[32]);
          end
          pending[i] = 1'b0;
        end
        if (req_ready[i] && req_valid[i]) pending[i] = 1'b1;
        prev_v[i]  = rsp_valid[i];
        prev_hs[i] = rsp_valid[i] & rsp_ready[i];
        prev_r[i]  = r;
        prev_f[i]  = rsp_flag[i];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  int bp_exp [16] = '{0, 1, 2, 3, 0, 1, -1, 3, 0, 1, -1, 3, 0, 1, -1, 3};

  initial begin
    rst       = 1'b1;
    rsp_ready = '0;
    for (int i = 0; i < REQ_NUM; i++) vsel[i] = i;
    req_valid = '1;
    drive();
    @(negedge clk);
    chk("rst_ready_gated", req_ready, 0);
    step();
    do_reset(2);
    @(negedge clk);
    chk("rst_idle", idle, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ready", req_ready, 0);
    step();

    // Single request: 2.0 * 3.0
    vsel[0] = 0; req_valid = 4'b0001; drive();
    @(negedge clk); chk("t1_grant", req_ready, 4'b0001); step();
    @(negedge clk); chk("t1_busy", idle, 0); chk("t1_no_rsp1", rsp_valid, 0); step();
    @(negedge clk); chk("t1_no_rsp2", rsp_valid, 0); step();
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_rsp_result", rsp_result[31:0], 32'h40C00000);
    chk("t1_rsp_flag", rsp_flag[0], 1);
    step();
    rsp_ready = 4'b0001;
    @(negedge clk); chk("t1_busy_at_hs", idle, 0); step();
    @(negedge clk); chk("t1_idle_after", idle, 1); chk("t1_rsp_clear", rsp_valid, 0); step();

    // Round robin with all requesters active and responses always accepted
    do_reset(2);
    for (int i = 0; i < REQ_NUM; i++) vsel[i] = i;
    rsp_ready = '1; hold_valid = 1'b1; req_valid = '1; drive();
    run(12);
    for (int k = 0; k < 12; k++) chk("rr_order", glog[k], k % 4);
    drain();

    // Back-pressure on requester 2
    rsp_ready = 4'b1011; hold_valid = 1'b1; req_valid = '1; drive();
    run(16);
    for (int k = 0; k < 16; k++) chk("bp_order", glog[k], bp_exp[k]);
    chk("bp_rsp2_valid", rsp_valid[2], 1);
    chk("bp_rsp2_result", rsp_result[64 +: 32], exp_q[2][0][31:0]);
    drain();

    // Wrap and skip: move ptr to 3, then requesters 1 and 3 only
    rsp_ready = '0; req_valid = 4'b0100; drive();
    @(negedge clk); chk("ws_setup_g2", req_ready, 4'b0100); step();
    req_valid = 4'b1010;
    @(negedge clk); chk("ws_grant3", req_ready, 4'b1000); step();
    @(negedge clk); chk("ws_grant1", req_ready, 4'b0010); step();
    drain();
    req_valid = '1;
    @(negedge clk); chk("ws_ptr_is_2", req_ready, 4'b0100); step();
    req_valid = '0;
    drain();

    // Simultaneous capture (1), response handshake (0) and grant (2)
    vsel[1] = 6; rsp_ready = '0; req_valid = 4'b0001; drive();
    @(negedge clk); chk("sim_g0", req_ready, 4'b0001); step();
    run(2);
    req_valid = 4'b0010;
    @(negedge clk); chk("sim_g1", req_ready, 4'b0010); step();
    run(1);
    req_valid = 4'b0101; rsp_ready = 4'b0001;
    @(negedge clk); chk("sim_g2_only", req_ready, 4'b0100); step();
    @(negedge clk);
    chk("sim_rsp_valid", rsp_valid, 4'b0010);
    chk("sim_rsp1_flag", rsp_flag[1], 0);
    chk("sim_regrant0", req_ready, 4'b0001);
    step();
    drain();

    // Reset in the cycle after the second grant
    rsp_ready = '0; req_valid = 4'b0011; drive();
    @(negedge clk); chk("rf_g1", req_ready, 4'b0010); step();
    @(negedge clk); chk("rf_g0", req_ready, 4'b0001); step();
    do_reset(1);
    repeat (5) begin
      @(negedge clk);
      chk("rf_no_rsp", rsp_valid, 0);
      chk("rf_idle", idle, 1);
      step();
    end
    req_valid = 4'b0011;
    @(negedge clk); chk("rf_next_grant0", req_ready, 4'b0001); step();
    req_valid = '0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
